dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Shares the single 512x32 data memory between the CPU load/store path and the FPU load/store path.
- The memory has one synchronous write port (a/d/we) and one asynchronous read port (dpra/dpo).
- After every reset, the block clears the whole memory to zero before it grants any access.
- It then arbitrates one access per cycle, round-robin, and returns registered read data with 1-cycle latency.

Parameters:
- ADDR_W, 9, memory address width.
- DATA_W, 32, memory data width.
- DEPTH, 512, words cleared after reset; must equal 2**ADDR_W.
- CLEAR_ON_RESET, 1, 1 = run the zero-fill sweep after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request; held with its fields until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  access accepted this cycle (combinational)
- cpu_rvalid  out  1  read data valid, 1-cycle pulse
- cpu_rdata  out  DATA_W  registered read data
- fpu_req, fpu_we, fpu_addr, fpu_wdata, fpu_gnt, fpu_rvalid, fpu_rdata  same as the CPU set, for the FPU
- mem_a  out  ADDR_W  memory write address
- mem_d  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_dpra  out  ADDR_W  memory read address
- mem_dpo  in  DATA_W  memory asynchronous read data
- busy  out  1  high while the clear sweep runs

Behaviour:
- States are CLEAR and RUN.
- Reset (asynchronous, rst=1):
  - state=CLEAR, clr_cnt=0, last_gnt=FPU so the CPU wins the first tie.
  - cpu_rvalid=fpu_rvalid=0, cpu_rdata=fpu_rdata=0.
  - Both gnt=0, busy=1.
  - Reset asserted mid-sweep or mid-access aborts immediately; any pending rvalid drops at once.
- CLEAR (CLEAR_ON_RESET=1):
  - Each cycle drives mem_we=1, mem_a=clr_cnt, mem_d=0, then clr_cnt increments.
  - The cycle that writes clr_cnt=DEPTH-1 is the last one; the next state is RUN.
  - The sweep takes exactly DEPTH cycles after rst deasserts.
  - Requests are ignored and both gnt stay 0. busy=1.
- CLEAR (CLEAR_ON_RESET=0): moves to RUN on the first clock edge after rst deasserts, with no writes.
- RUN arbitration:
  - busy=0. At most one gnt per cycle.
  - If only one requester asserts req, it is granted.
  - If both assert req, the requester not recorded in last_gnt is granted.
  - last_gnt updates only on a grant.
  - No request means no grant, and last_gnt holds.
- RUN write grant: mem_we=1, mem_a=addr, mem_d=wdata. The write commits on that edge.
- RUN read grant:
  - mem_dpra=addr and mem_we=0.
  - mem_dpo is captured into that requester's rdata on the edge.
  - That requester's rvalid is 1 in the following cycle only.
- Idle memory outputs: when no write is granted, mem_we=0, mem_a=0, mem_d=0. When no read is granted, mem_dpra=0.
- rdata holds its last value while rvalid=0. The other requester's rdata and rvalid are unaffected.
- Read-after-write: a read granted in the cycle after a write to the same address returns the new data.
- Back-to-back reads: a requester may be re-granted while its rvalid is high. Sustained single-requester throughput is 1 access per cycle.
- Addresses are used unmodified; no wrap or bounds logic is needed, since 2**ADDR_W = DEPTH.

Test Plan:
- Clear sweep:
  - Backdoor-fill memory with 0xFFFFFFFF, pulse rst, hold cpu_req=1 read.
  - Required: busy=1 and cpu_gnt=0 for exactly 512 cycles; mem_we=1 with mem_a stepping 0..511.
  - Then a read of 0x1FF returns 0x00000000.
- CPU write then read:
  - Write 0x0A5 with 0xDEADBEEF, then read 0x0A5.
  - Required: cpu_gnt high each cycle; cpu_rvalid pulses one cycle after the read grant with cpu_rdata=0xDEADBEEF; fpu_rvalid stays 0.
- Contention:
  - Both request reads continuously for 6 cycles, starting right after the sweep.
  - Required: grants go CPU,FPU,CPU,FPU,CPU,FPU; each rvalid pulses on alternate cycles.
- Cross-requester RAW:
  - FPU writes 0x010=0x3F800000; CPU reads 0x010 the next cycle.
  - Required: cpu_rdata=0x3F800000.
- Reset mid-sweep:
  - Assert rst when clr_cnt=100, release after 3 cycles.
  - Required: rvalid/gnt=0 during reset; the sweep restarts at mem_a=0 and busy lasts 512 more cycles.
- Read does not write:
  - CPU read grant at 0x1FF.
  - Required: mem_we=0 and mem_dpra=0x1FF in the grant cycle; memory contents are unchanged.

Source files
------------

// File: rtl/dm_port_arbiter_if.sv
// Bundle of the CPU and FPU load/store channels and the data-memory port.
// The arbiter connects through "slave"; the requesters and the memory model use "master".
interface dm_port_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              fpu_req, fpu_we, fpu_gnt, fpu_rvalid;
  logic [ADDR_W-1:0] fpu_addr;
  logic [DATA_W-1:0] fpu_wdata, fpu_rdata;
  logic [ADDR_W-1:0] mem_a, mem_dpra;
  logic [DATA_W-1:0] mem_d, mem_dpo;
  logic              mem_we, busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  fpu_req, fpu_we, fpu_addr, fpu_wdata,
    input  mem_dpo,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output fpu_gnt, fpu_rvalid, fpu_rdata,
    output mem_a, mem_d, mem_we, mem_dpra, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output fpu_req, fpu_we, fpu_addr, fpu_wdata,
    output mem_dpo,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  fpu_gnt, fpu_rvalid, fpu_rdata,
    input  mem_a, mem_d, mem_we, mem_dpra, busy
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Round-robin CPU/FPU arbiter for the shared data memory. After reset it zero-fills
// the memory before granting, then serves one access per cycle with registered read data.
module dm_port_arbiter #(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 512,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  dm_port_arbiter_if.slave   bus
);
  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              last_gnt;   // 1 = FPU held the last grant
  logic              clearing, run;
  logic              cpu_gnt, fpu_gnt, cpu_wr, fpu_wr, cpu_rd, fpu_rd;
  logic              cpu_rvalid, fpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata, fpu_rdata;

  assign run      = (state == RUN);
  assign clearing = (state == CLEAR) && CLEAR_ON_RESET;

  // On a tie the requester that did not win last time takes the slot.
  assign cpu_gnt = run && bus.cpu_req && (!bus.fpu_req || last_gnt);
  assign fpu_gnt = run && bus.fpu_req && (!bus.cpu_req || !last_gnt);
  assign cpu_wr  = cpu_gnt &&  bus.cpu_we;
  assign cpu_rd  = cpu_gnt && !bus.cpu_we;
  assign fpu_wr  = fpu_gnt &&  bus.fpu_we;
  assign fpu_rd  = fpu_gnt && !bus.fpu_we;

  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_a    = '0;
    bus.mem_d    = '0;
    bus.mem_dpra = '0;
    if (clearing) begin
      bus.mem_we = 1'b1;
      bus.mem_a  = clr_cnt;
    end else if (cpu_wr) begin
      bus.mem_we = 1'b1;
      bus.mem_a  = bus.cpu_addr;
      bus.mem_d  = bus.cpu_wdata;
    end else if (fpu_wr) begin
      bus.mem_we = 1'b1;
      bus.mem_a  = bus.fpu_addr;
      bus.mem_d  = bus.fpu_wdata;
    end
    if (cpu_rd)      bus.mem_dpra = bus.cpu_addr;
    else if (fpu_rd) bus.mem_dpra = bus.fpu_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      last_gnt   <= 1'b1;
      cpu_rvalid <= 1'b0;
      fpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      fpu_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_rd;
      fpu_rvalid <= fpu_rd;
      if (cpu_rd) cpu_rdata <= bus.mem_dpo;
      if (fpu_rd) fpu_rdata <= bus.mem_dpo;
      case (state)
        CLEAR: begin
          if (!CLEAR_ON_RESET) begin
            state <= RUN;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == ADDR_W'(DEPTH - 1)) state <= RUN;
          end
        end
        RUN: begin
          if (cpu_gnt)      last_gnt <= 1'b0;
          else if (fpu_gnt) last_gnt <= 1'b1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.fpu_gnt    = fpu_gnt;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.fpu_rvalid = fpu_rvalid;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.fpu_rdata  = fpu_rdata;
  assign bus.busy       = (state == CLEAR);
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: expected read data is queued at grant time and
// checked by an independent monitor when rvalid appears; a behavioural 512x32 RAM sits on the memory port.
module tb_dm_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_port_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  dm_port_arbiter #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .CLEAR_ON_RESET(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] mem [512];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a] <= bus.mem_d;
  assign bus.mem_dpo = mem[bus.mem_dpra];

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] cpu_q[$];
  logic [31:0] fpu_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every rvalid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cpu_rvalid) begin
        if (cpu_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL cpu_rvalid_unexpected: got rvalid=1 rdata=%h, expected rvalid=0", bus.cpu_rdata);
        end else chk("cpu_rdata", bus.cpu_rdata, cpu_q.pop_front());
      end
      if (bus.fpu_rvalid) begin
        if (fpu_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL fpu_rvalid_unexpected: got rvalid=1 rdata=%h, expected rvalid=0", bus.fpu_rdata);
        end else chk("fpu_rdata", bus.fpu_rdata, fpu_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks n cycles of the clear sweep, then returns just after the last checked edge.
  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("sweep_ctl[%0d]", i),
          32'({bus.busy, bus.cpu_gnt, bus.fpu_gnt, bus.mem_we}), 32'b1001);
      chk($sformatf("sweep_addr[%0d]", i), 32'(bus.mem_a), 32'(i));
      chk($sformatf("sweep_data[%0d]", i), bus.mem_d, 32'h0);
      step();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},   32'(bus.busy), 32'd1);
    chk({tag, "_gnt"},    32'({bus.cpu_gnt, bus.fpu_gnt}), 32'd0);
    chk({tag, "_rvalid"}, 32'({bus.cpu_rvalid, bus.fpu_rvalid}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h1FF; bus.cpu_wdata = '0;
    bus.fpu_req = 1'b0; bus.fpu_we = 1'b0; bus.fpu_addr = '0;     bus.fpu_wdata = '0;
    for (int k = 0; k < 512; k++) mem[k] <= 32'hFFFF_FFFF;

    // Reset state and full clear sweep with a CPU read held pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_rdata", bus.cpu_rdata | bus.fpu_rdata, 32'h0);
    step();
    rst = 1'b0;
    sweep(512);

    // First RUN cycle: the held read of 0x1FF is granted and must not write
    @(negedge clk);
    chk("rd1ff_gnt", 32'({bus.cpu_gnt, bus.fpu_gnt, bus.busy}), 32'b100);
    chk("rd1ff_we", 32'(bus.mem_we), 32'd0);
    chk("rd1ff_dpra", 32'(bus.mem_dpra), 32'h1FF);
    cpu_q.push_back(32'h0);
    step();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("rd1ff_unchanged", mem[511], 32'h0);
    chk("idle_gnt", 32'({bus.cpu_gnt, bus.fpu_gnt}), 32'd0);

    // CPU write then read of 0x0A5
    step();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 9'h0A5; bus.cpu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_gnt", 32'(bus.cpu_gnt), 32'd1);
    chk("wr_port", 32'({bus.mem_we, bus.mem_a}), 32'({1'b1, 9'h0A5}));
    chk("wr_data", bus.mem_d, 32'hDEAD_BEEF);
    step();
    bus.cpu_we = 1'b0;
    @(negedge clk);
    chk("rd_gnt", 32'(bus.cpu_gnt), 32'd1);
    chk("rd_dpra", 32'(bus.mem_dpra), 32'h0A5);
    cpu_q.push_back(32'hDEAD_BEEF);
    step();
    bus.cpu_req = 1'b0;
    step();

    // FPU writes 0x010, CPU reads it on the very next cycle
    bus.fpu_req = 1'b1; bus.fpu_we = 1'b1; bus.fpu_addr = 9'h010; bus.fpu_wdata = 32'h3F80_0000;
    @(negedge clk);
    chk("raw_fpu_gnt", 32'({bus.cpu_gnt, bus.fpu_gnt}), 32'b01);
    step();
    bus.fpu_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h010;
    @(negedge clk);
    chk("raw_cpu_gnt", 32'({bus.cpu_gnt, bus.fpu_gnt}), 32'b10);
    cpu_q.push_back(32'h3F80_0000);
    step();
    bus.cpu_req = 1'b0;
    step();

    // Pending rvalid must drop the instant reset is asserted
    bus.cpu_req = 1'b1; bus.cpu_addr = 9'h0A5;
    step();
    bus.cpu_req = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outputs("abort_rvalid");
    step();
    rst = 1'b0;

    // Reset mid-sweep at clr_cnt=100, both requesters reading and held for contention
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h020;
    bus.fpu_req = 1'b1; bus.fpu_we = 1'b0; bus.fpu_addr = 9'h021;
    sweep(100);
    @(negedge clk);
    chk("midsweep_a", 32'(bus.mem_a), 32'd100);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midsweep_rst");
    chk("midsweep_rst_a", 32'(bus.mem_a), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs("midsweep_hold");
    end
    step();
    rst = 1'b0;
    sweep(512);
    mem[9'h020] <= 32'h1111_1111;
    mem[9'h021] <= 32'h2222_2222;

    // Contention right after the sweep: strict alternation starting with CPU
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rr_gnt[%0d]", i), 32'({bus.cpu_gnt, bus.fpu_gnt}),
          (i % 2 == 0) ? 32'b10 : 32'b01);
      if (i % 2 == 0) cpu_q.push_back(32'h1111_1111);
      else            fpu_q.push_back(32'h2222_2222);
      step();
    end
    bus.cpu_req = 1'b0; bus.fpu_req = 1'b0;
    repeat (3) step();

    chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    chk("fpu_q_drained", 32'(fpu_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
